// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and frame layout for the sensor access scheduler
package sched_pkg;

    localparam int FRAME_W = 40;

    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CHK_LSB      = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RESP    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first set bit at or after a pointer
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    pending,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_any
);

    // First pass finds the lowest set bit (the wrap-around winner); the second
    // pass overrides it with the lowest set bit at or above the pointer.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i] && (ID_W'(i) >= ptr)) begin
                grant_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/sensor_access_scheduler.sv
// rtl/sensor_access_scheduler.sv - round-robin sequencer for the shared temperature/humidity sensor
module sensor_access_scheduler
    import sched_pkg::*;
#(
    parameter int REQ_COUNT      = 4,
    parameter int ID_W           = 2,
    parameter int MIN_GAP_CYCLES = 100_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                 clock_50Mhz,
    input  logic                 reset,
    input  logic [REQ_COUNT-1:0] req,
    input  logic                 sensor_done,
    input  logic [FRAME_W-1:0]   sensor_frame,
    output logic                 enable_sensor,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [FRAME_W-1:0]   resp_frame,
    output logic                 resp_chk_ok,
    output logic                 resp_timeout,
    output logic                 busy
);

    localparam int CNT_MAX = (MIN_GAP_CYCLES > TIMEOUT_CYCLES) ? MIN_GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t               state;
    state_t               state_n;
    logic [REQ_COUNT-1:0] pending;
    logic [REQ_COUNT-1:0] clr_mask;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      cur_id;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           byte_sum;

    rr_arbiter #(
        .N    (REQ_COUNT),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .pending   (pending),
        .ptr       (ptr),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign byte_sum = sensor_frame[HUM_INT_LSB +: 8] + sensor_frame[HUM_DEC_LSB +: 8]
                    + sensor_frame[TEMP_INT_LSB +: 8] + sensor_frame[TEMP_DEC_LSB +: 8];

    assign busy = (state != IDLE);

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state <= HOLDOFF;
        end else begin
            state <= state_n;
        end
    end

    // WAIT and HOLDOFF leave on the cycle whose decrement would reach zero.
    always_comb begin
        state_n       = state;
        enable_sensor = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            IDLE:    if (grant_any) state_n = ISSUE;
            ISSUE: begin
                enable_sensor = 1'b1;
                state_n       = WAIT;
            end
            WAIT:    if (sensor_done || (cnt <= CNT_ONE)) state_n = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_n    = HOLDOFF;
            end
            HOLDOFF: if (cnt <= CNT_ONE) state_n = IDLE;
            default: state_n = HOLDOFF;
        endcase
    end

    always_comb begin
        clr_mask = '0;
        if (state == RESP) clr_mask[cur_id] = 1'b1;
    end

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            pending      <= '0;
            ptr          <= '0;
            cur_id       <= '0;
            cnt          <= GAP_LOAD;
            resp_id      <= '0;
            resp_frame   <= '0;
            resp_chk_ok  <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            // A request landing in its own response cycle survives the clear.
            pending <= (pending & ~clr_mask) | req;
            case (state)
                IDLE:  if (grant_any) cur_id <= grant_id;
                ISSUE: cnt <= TMO_LOAD;
                WAIT: begin
                    if (sensor_done) begin
                        resp_id      <= cur_id;
                        resp_frame   <= sensor_frame;
                        resp_chk_ok  <= (byte_sum == sensor_frame[CHK_LSB +: 8]);
                        resp_timeout <= 1'b0;
                    end else if (cnt <= CNT_ONE) begin
                        resp_id      <= cur_id;
                        resp_frame   <= '0;
                        resp_chk_ok  <= 1'b0;
                        resp_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    ptr <= (cur_id == ID_W'(REQ_COUNT - 1)) ? '0 : cur_id + 1'b1;
                    cnt <= GAP_LOAD;
                end
                HOLDOFF: if (cnt > CNT_ONE) cnt <= cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule
